// File: rtl/regfile_writeback_pkg.sv
// Shared types and sizing for the write-back register file slice.
package regfile_writeback_pkg;

    localparam int unsigned REG_COUNT     = 32;
    localparam int unsigned REG_IDX_W     = 5;
    localparam int unsigned DATA_W_DEFAULT = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } wb_state_t;

    // Index of the upper half of a double-word write; wraps 31 -> 0.
    function automatic logic [REG_IDX_W-1:0] next_idx(input logic [REG_IDX_W-1:0] idx);
        return REG_IDX_W'(idx + REG_IDX_W'(1));
    endfunction

endpackage

// File: rtl/regfile_writeback_dec5to32.sv
// 5-to-32 one-hot decoder with enable; output is all zeros when disabled.
import regfile_writeback_pkg::*;

module dec5to32 (
    input  logic [REG_IDX_W-1:0] idx,
    input  logic                 en,
    output logic [REG_COUNT-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// 32-entry register file write port with single and double-word write-back.
import regfile_writeback_pkg::*;

module regfile_writeback #(
    parameter bit          ZERO_R0 = 1'b1,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wb_valid,
    output logic                        wb_ready,
    input  logic                        wb_dbl,
    input  logic [REG_IDX_W-1:0]        wb_rd,
    input  logic [DATA_W-1:0]           wb_data0,
    input  logic [DATA_W-1:0]           wb_data1,
    output logic [REG_COUNT-1:0]        wr_onehot,
    output logic [REG_COUNT*DATA_W-1:0] regs_flat,
    output logic                        busy
);

    wb_state_t             state;
    logic [REG_IDX_W-1:0]  lat_rd;
    logic [DATA_W-1:0]     lat_data;

    logic                  accept;
    logic                  wr_en;
    logic [REG_IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0]     wr_data;

    assign wb_ready = (state == IDLE) && !rst;
    assign busy     = (state == SECOND) && !rst;
    assign accept   = wb_valid && wb_ready;

    // Select this cycle's write: the incoming first beat or the latched second beat.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = wb_rd;
        wr_data = wb_data0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    wr_en = accept;
                end
                SECOND: begin
                    wr_en   = 1'b1;
                    wr_idx  = lat_rd;
                    wr_data = lat_data;
                end
                default: begin
                    wr_en = 1'b0;
                end
            endcase
        end
        if (ZERO_R0 && (wr_idx == '0)) begin
            wr_en = 1'b0;
        end
    end

    dec5to32 u_dec (
        .idx    (wr_idx),
        .en     (wr_en),
        .onehot (wr_onehot)
    );

    // Sequencer for the second beat of a double-word write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lat_rd   <= '0;
            lat_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && wb_dbl) begin
                        state    <= SECOND;
                        lat_rd   <= next_idx(wb_rd);
                        lat_data <= wb_data1;
                    end
                end
                SECOND: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    for (genvar k = 0; k < REG_COUNT; k++) begin : g_reg
        if (ZERO_R0 && (k == 0)) begin : g_zero
            assign regs_flat[k*DATA_W +: DATA_W] = '0;
        end else begin : g_flop
            logic [DATA_W-1:0] q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else if (wr_onehot[k]) begin
                    q <= wr_data;
                end
            end

            assign regs_flat[k*DATA_W +: DATA_W] = q;
        end
    end

endmodule
